// File: rtl/led_word_rx.sv
// Receiver for the single-wire LED bit link: idle low, high start bit,
// WIDTH data bits LSB first, low stop bit, each bit lasting BIT_PERIOD clocks.
module led_word_rx #(
  parameter int BIT_PERIOD = 1251,
  parameter int WIDTH      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_in,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int HALF = BIT_PERIOD / 2;
  localparam int CW   = $clog2(BIT_PERIOD);
  localparam int BW   = $clog2(WIDTH);

  localparam logic [CW-1:0] HALF_LOAD   = CW'(HALF - 1);
  localparam logic [CW-1:0] PERIOD_LOAD = CW'(BIT_PERIOD - 1);
  localparam logic [BW-1:0] LAST_BIT    = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_LOW
  } state_t;

  state_t           state;
  logic             sync1;
  logic             rx_s;
  logic             rx_prev;
  logic [CW-1:0]    period_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift;
  logic             rise;
  logic             sample;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      rx_s    <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      sync1   <= rx_in;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  assign rise   = rx_s & ~rx_prev;
  assign sample = (period_cnt == '0);

  // Counting down to zero from HALF-1 lands the first sample exactly HALF
  // cycles after the edge cycle; every later sample reloads a full period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      period_cnt <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state      <= START;
            period_cnt <= HALF_LOAD;
            busy       <= 1'b1;
          end
        end
        START: begin
          if (sample) begin
            if (rx_s) begin
              state      <= DATA;
              bit_cnt    <= '0;
              period_cnt <= PERIOD_LOAD;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            period_cnt <= period_cnt - CW'(1);
          end
        end
        DATA: begin
          if (sample) begin
            shift      <= {rx_s, shift[WIDTH-1:1]};
            period_cnt <= PERIOD_LOAD;
            if (bit_cnt == LAST_BIT) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            period_cnt <= period_cnt - CW'(1);
          end
        end
        STOP: begin
          if (sample) begin
            period_cnt <= PERIOD_LOAD;
            if (!rx_s) begin
              word_out   <= shift;
              word_valid <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_LOW;
            end
          end else begin
            period_cnt <= period_cnt - CW'(1);
          end
        end
        // A stuck-high line must fall before a new start edge can count.
        WAIT_LOW: begin
          if (!rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_word_rx.sv
// Directed bench for led_word_rx with a short bit period; expected words and
// pulse timing come from the framing rules, not from the DUT.
module tb_led_word_rx;

  localparam int BP    = 16;
  localparam int WIDTH = 32;
  localparam int HALF  = BP / 2;
  localparam int VALID_LAT = 3 + HALF + (WIDTH + 1) * BP;

  logic             clk = 1'b0;
  logic             rst;
  logic             rx_in;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             frame_err;
  logic             busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int err_count = 0;
  logic prev_pulse = 1'b0;
  logic [31:0] valid_words[$];
  int          valid_cycs[$];

  led_word_rx #(.BIT_PERIOD(BP), .WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .rx_in(rx_in),
    .word_out(word_out),
    .word_valid(word_valid),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          stop_high;
    int          exp_valid;
    int          exp_err;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic driveLine(input logic value, input int n);
    rx_in = value;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] data, input int stop_high,
                               output int start_cyc, output logic busy_mid);
    start_cyc = cyc;
    busy_mid  = 1'b0;
    driveLine(1'b1, BP);
    for (int i = 0; i < WIDTH; i++) driveLine(data[i], BP);
    if (stop_high > 0) begin
      driveLine(1'b1, stop_high / 2);
      busy_mid = busy;
      driveLine(1'b1, stop_high - stop_high / 2);
    end
    driveLine(1'b0, BP);
  endtask

  // Pulse monitor: records every word_valid and frame_err, checks they are
  // mutually exclusive and never longer than one cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (word_valid || frame_err) begin
        checkOutput("pulse_exclusive", {31'b0, word_valid & frame_err}, 32'd0);
        checkOutput("pulse_width", {31'b0, prev_pulse}, 32'd0);
      end
      if (word_valid) begin
        valid_words.push_back(word_out);
        valid_cycs.push_back(cyc);
      end
      if (frame_err) err_count++;
      prev_pulse = word_valid | frame_err;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  initial begin
    int   s, s2, v0, e0;
    logic bm;
    logic saw_busy;
    logic [31:0] held;
    logic [31:0] abort_data;

    vecs[0] = '{32'h34D51531, 0,   1, 0, 32'h34D51531};
    vecs[1] = '{32'hFFFFFFFF, 100, 0, 1, 32'h34D51531};
    vecs[2] = '{32'h00000001, 0,   1, 0, 32'h00000001};
    vecs[3] = '{32'h80000000, 0,   1, 0, 32'h80000000};
    vecs[4] = '{32'h00000000, 0,   1, 0, 32'h00000000};

    rst   = 1'b1;
    rx_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_word", word_out, 32'd0);
    checkOutput("reset_valid", {31'b0, word_valid}, 32'd0);
    checkOutput("reset_err", {31'b0, frame_err}, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    driveLine(1'b0, 10);

    for (int i = 0; i < 5; i++) begin
      v0 = valid_words.size();
      e0 = err_count;
      applyStimulus(vecs[i].data, vecs[i].stop_high, s, bm);
      driveLine(1'b0, 20);
      checkOutput("valid_count", 32'(valid_words.size() - v0), 32'(vecs[i].exp_valid));
      checkOutput("err_count", 32'(err_count - e0), 32'(vecs[i].exp_err));
      checkOutput("word_out", word_out, vecs[i].exp_word);
      checkOutput("busy_after", {31'b0, busy}, 32'd0);
      if (vecs[i].exp_valid == 1 && valid_words.size() > v0)
        checkOutput("valid_time", 32'(valid_cycs[valid_cycs.size() - 1] - s), 32'(VALID_LAT));
      if (vecs[i].stop_high > 0)
        checkOutput("busy_stuck_high", {31'b0, bm}, 32'd1);
    end

    // Back-to-back frames with a single-period stop bit.
    v0 = valid_words.size();
    applyStimulus(32'h7F7DF7D7, 0, s, bm);
    applyStimulus(32'h55555556, 0, s2, bm);
    driveLine(1'b0, 20);
    checkOutput("b2b_count", 32'(valid_words.size() - v0), 32'd2);
    if (valid_words.size() - v0 == 2) begin
      checkOutput("b2b_word0", valid_words[v0], 32'h7F7DF7D7);
      checkOutput("b2b_word1", valid_words[v0 + 1], 32'h55555556);
      checkOutput("b2b_spacing", 32'(valid_cycs[v0 + 1] - valid_cycs[v0]), 32'((WIDTH + 2) * BP));
    end

    // Short glitch: START is entered, then abandoned at the half-bit check.
    v0 = valid_words.size();
    e0 = err_count;
    held = word_out;
    driveLine(1'b1, 3);
    checkOutput("glitch_busy_start", {31'b0, busy}, 32'd1);
    driveLine(1'b0, 20);
    checkOutput("glitch_busy_after", {31'b0, busy}, 32'd0);
    checkOutput("glitch_pulses", 32'(valid_words.size() - v0 + err_count - e0), 32'd0);
    checkOutput("glitch_word", word_out, held);

    // Reset in the middle of data bit 10 aborts the frame.
    v0 = valid_words.size();
    abort_data = 32'hDEADBEEF;
    driveLine(1'b1, BP);
    for (int i = 0; i < 10; i++) driveLine(abort_data[i], BP);
    driveLine(abort_data[10], 5);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_word", word_out, 32'd0);
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_valid", {31'b0, word_valid}, 32'd0);
    checkOutput("abort_err", {31'b0, frame_err}, 32'd0);
    rx_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    driveLine(1'b0, 20);
    checkOutput("abort_no_pulse", 32'(valid_words.size() - v0), 32'd0);
    applyStimulus(32'hA5A5A5A5, 0, s, bm);
    driveLine(1'b0, 20);
    checkOutput("after_abort_count", 32'(valid_words.size() - v0), 32'd1);
    checkOutput("after_abort_word", word_out, 32'hA5A5A5A5);

    // Constant-low line for 1000 cycles.
    v0 = valid_words.size();
    e0 = err_count;
    saw_busy = 1'b0;
    rx_in = 1'b0;
    repeat (1000) begin
      @(posedge clk);
      #1;
      if (busy) saw_busy = 1'b1;
    end
    checkOutput("low_busy", {31'b0, saw_busy}, 32'd0);
    checkOutput("low_pulses", 32'(valid_words.size() - v0 + err_count - e0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
